// File: rtl/ecg_delay_pair_if.sv
// Sample-stream bundle between the ECG sample source and the delay-pair feeder.
// The slave side consumes samples and emits (x[n], x[n-DELAY]) pairs.
interface ecg_delay_pair_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 8
);
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              primed;
    logic [PTR_W-1:0]  fill_count;

    modport master (
        output clear, in_valid, in_data,
        input  out_valid, data_a, data_b, primed, fill_count
    );

    modport slave (
        input  clear, in_valid, in_data,
        output out_valid, data_a, data_b, primed, fill_count
    );
endinterface

// File: rtl/ecg_delay_pair.sv
// Feeds the signed subtracter with (x[n], x[n-DELAY]) from a circular sample buffer.
// Pairs start only once DELAY samples have been stored since reset or clear.
module ecg_delay_pair #(
    parameter int DATA_W = 8,
    parameter int DELAY  = 4,
    parameter int PTR_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ecg_delay_pair_if.slave bus
);
    localparam int ADDR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DELAY - 1);
    localparam logic [PTR_W-1:0]  LAST_FILL = PTR_W'(DELAY - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0]  r_fill_count;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_fill_accept;
    logic              w_run_accept;
    logic              w_primed;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values, which the read-before-write path relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: each combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (bus.clear) begin
            w_state_next = ST_FILL;
        end else begin
            case (r_state)
                ST_FILL: if (bus.in_valid && (r_fill_count == LAST_FILL)) w_state_next = ST_RUN;
                ST_RUN:  w_state_next = ST_RUN;
                default: w_state_next = ST_FILL;
            endcase
        end
    end

    // A sample arriving together with clear is dropped.
    always_comb begin
        w_accept      = bus.in_valid && !bus.clear;
        w_fill_accept = w_accept && (r_state == ST_FILL);
        w_run_accept  = w_accept && (r_state == ST_RUN);
        w_primed      = (r_state == ST_RUN);
    end

    assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_fill_count <= '0;
            r_out_valid  <= 1'b0;
            r_data_a     <= '0;
            r_data_b     <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.clear) begin
                r_wr_ptr     <= '0;
                r_fill_count <= '0;
            end else if (w_accept) begin
                r_wr_ptr <= w_wr_ptr_next;
                if (w_fill_accept) begin
                    r_fill_count <= r_fill_count + PTR_W'(1);
                end
                if (w_run_accept) begin
                    r_out_valid <= 1'b1;
                    r_data_a    <= bus.in_data;
                    r_data_b    <= r_mem[r_wr_ptr];
                end
            end
        end
    end

    // NOTE: the sample RAM has no reset; FILL rewrites every live entry before RUN reads one.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.data_a     = r_data_a;
    assign bus.data_b     = r_data_b;
    assign bus.primed     = w_primed;
    assign bus.fill_count = r_fill_count;
endmodule

// File: tb/tb_ecg_delay_pair.sv
// Bench for ecg_delay_pair: a sample-history model checked every cycle on two
// instances (DELAY=4 and DELAY=1), plus hand-computed directed expectations.
module tb_ecg_delay_pair;
    localparam int DATA_W = 8;
    localparam int PTR_W  = 8;

    logic clk = 1'b0;
    logic rst_n4;
    logic rst_n1;

    always #5 clk = ~clk;

    ecg_delay_pair_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus4 ();
    ecg_delay_pair_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus1 ();

    ecg_delay_pair #(.DATA_W(DATA_W), .DELAY(4), .PTR_W(PTR_W)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n4),
        .bus   (bus4.slave)
    );

    ecg_delay_pair #(.DATA_W(DATA_W), .DELAY(1), .PTR_W(PTR_W)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: full sample history since the last restart; pair is (newest, DELAY back).
    logic [7:0] hist [2][256];
    int         cnt [2];
    logic       exp_valid [2];
    logic [7:0] exp_a [2];
    logic [7:0] exp_b [2];
    logic       exp_primed [2];
    int         exp_fill [2];

    function automatic int dly(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic model_reset(input int i);
        cnt[i]        = 0;
        exp_valid[i]  = 1'b0;
        exp_a[i]      = 8'h00;
        exp_b[i]      = 8'h00;
        exp_primed[i] = 1'b0;
        exp_fill[i]   = 0;
    endtask

    task automatic model_step(input int i, input logic clr, input logic v, input logic [7:0] d);
        if (clr) begin
            cnt[i]        = 0;
            exp_valid[i]  = 1'b0;
            exp_primed[i] = 1'b0;
            exp_fill[i]   = 0;
        end else if (v) begin
            if (cnt[i] >= dly(i)) begin
                exp_valid[i] = 1'b1;
                exp_a[i]     = d;
                exp_b[i]     = hist[i][cnt[i] - dly(i)];
            end else begin
                exp_valid[i] = 1'b0;
            end
            if (cnt[i] < 256) hist[i][cnt[i]] = d;
            cnt[i]        = cnt[i] + 1;
            exp_fill[i]   = (cnt[i] < dly(i)) ? cnt[i] : dly(i);
            exp_primed[i] = (cnt[i] >= dly(i));
        end else begin
            exp_valid[i] = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n4);
        if (!rst_n4) model_reset(0);
        else model_step(0, bus4.clear, bus4.in_valid, bus4.in_data);
    end

    initial forever begin
        @(posedge clk or negedge rst_n1);
        if (!rst_n1) model_reset(1);
        else model_step(1, bus1.clear, bus1.in_valid, bus1.in_data);
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial forever begin
        @(negedge clk);
        check("d4_out_valid",  {31'd0, bus4.out_valid}, {31'd0, exp_valid[0]});
        check("d4_data_a",     {24'd0, bus4.data_a},    {24'd0, exp_a[0]});
        check("d4_data_b",     {24'd0, bus4.data_b},    {24'd0, exp_b[0]});
        check("d4_primed",     {31'd0, bus4.primed},    {31'd0, exp_primed[0]});
        check("d4_fill_count", {24'd0, bus4.fill_count}, exp_fill[0]);
        check("d1_out_valid",  {31'd0, bus1.out_valid}, {31'd0, exp_valid[1]});
        check("d1_data_a",     {24'd0, bus1.data_a},    {24'd0, exp_a[1]});
        check("d1_data_b",     {24'd0, bus1.data_b},    {24'd0, exp_b[1]});
        check("d1_primed",     {31'd0, bus1.primed},    {31'd0, exp_primed[1]});
        check("d1_fill_count", {24'd0, bus1.fill_count}, exp_fill[1]);
    end

    task automatic drive4(input logic v, input logic [7:0] d, input logic c);
        bus4.in_valid = v;
        bus4.in_data  = d;
        bus4.clear    = c;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        bus4.clear    = 1'b0;
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic c);
        bus1.in_valid = v;
        bus1.in_data  = d;
        bus1.clear    = c;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.clear    = 1'b0;
    endtask

    initial begin
        logic [7:0] x;
        logic       pat [7];
        int         diff;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst_n4 = 1'b0;
        rst_n1 = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.clear = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.clear = 1'b0;
        repeat (3) @(negedge clk);
        rst_n4 = 1'b1;
        rst_n1 = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("rst_data_a",    {24'd0, bus4.data_a},    32'd0);
        check("rst_data_b",    {24'd0, bus4.data_b},    32'd0);
        check("rst_primed",    {31'd0, bus4.primed},    32'd0);
        check("rst_fill",      {24'd0, bus4.fill_count}, 32'd0);

        // 1: first four samples only fill the buffer
        for (int s = 1; s <= 4; s++) begin
            drive4(1'b1, 8'(s), 1'b0);
            check("t1_no_valid", {31'd0, bus4.out_valid}, 32'd0);
            check("t1_primed",   {31'd0, bus4.primed}, (s == 4) ? 32'd1 : 32'd0);
            check("t1_fill",     {24'd0, bus4.fill_count}, s);
        end
        drive4(1'b1, 8'd5, 1'b0);
        check("t1_v5", {31'd0, bus4.out_valid}, 32'd1);
        check("t1_a5", {24'd0, bus4.data_a}, 32'd5);
        check("t1_b5", {24'd0, bus4.data_b}, 32'd1);
        drive4(1'b1, 8'd6, 1'b0);
        check("t1_a6", {24'd0, bus4.data_a}, 32'd6);
        check("t1_b6", {24'd0, bus4.data_b}, 32'd2);

        // 2: x[n]=3n-30 over five pointer wraps
        for (int n = 0; n < 20; n++) begin
            x = 8'(3 * n - 30);
            drive4(1'b1, x, 1'b0);
            if (n == 4) begin
                check("t2_a_n4", {24'd0, bus4.data_a}, 32'h0000_00EE);
                check("t2_b_n4", {24'd0, bus4.data_b}, 32'h0000_00E2);
            end
        end
        check("t2_a_last", {24'd0, bus4.data_a}, 32'd27);
        check("t2_b_last", {24'd0, bus4.data_b}, 32'd15);

        // 3: gaps in RUN; outputs hold between pulses
        x = 8'd0;
        for (int k = 0; k < 7; k++) begin
            drive4(pat[k], 8'(40 + k), 1'b0);
            if (pat[k]) x = 8'(40 + k);
            check("t3_valid_mirror", {31'd0, bus4.out_valid}, {31'd0, pat[k]});
            check("t3_a_hold",       {24'd0, bus4.data_a},    {24'd0, x});
        end

        // 4: full-scale extremes
        drive4(1'b1, 8'h80, 1'b0);
        drive4(1'b1, 8'h00, 1'b0);
        drive4(1'b1, 8'h00, 1'b0);
        drive4(1'b1, 8'h00, 1'b0);
        drive4(1'b1, 8'h7F, 1'b0);
        check("t4_a", {24'd0, bus4.data_a}, 32'h0000_007F);
        check("t4_b", {24'd0, bus4.data_b}, 32'h0000_0080);
        diff = int'($signed(bus4.data_a)) - int'($signed(bus4.data_b));
        check("t4_diff", diff, 32'd255);

        // 5: clear with a coincident sample
        drive4(1'b1, 8'd99, 1'b1);
        check("t5_fill",   {24'd0, bus4.fill_count}, 32'd0);
        check("t5_valid",  {31'd0, bus4.out_valid},  32'd0);
        check("t5_primed", {31'd0, bus4.primed},     32'd0);
        check("t5_a_held", {24'd0, bus4.data_a},     32'h0000_007F);
        for (int s = 0; s < 4; s++) begin
            drive4(1'b1, 8'(50 + s), 1'b0);
            check("t5_refill_no_valid", {31'd0, bus4.out_valid}, 32'd0);
        end
        drive4(1'b1, 8'd54, 1'b0);
        check("t5_valid5", {31'd0, bus4.out_valid}, 32'd1);
        check("t5_a5",     {24'd0, bus4.data_a},    32'd54);
        check("t5_b5",     {24'd0, bus4.data_b},    32'd50);

        // 6: DELAY=1 pairs consecutive samples; async reset mid-stream
        drive1(1'b1, 8'd10, 1'b0);
        check("t6_v10",      {31'd0, bus1.out_valid}, 32'd0);
        check("t6_primed10", {31'd0, bus1.primed},    32'd1);
        drive1(1'b1, 8'd20, 1'b0);
        check("t6_a20", {24'd0, bus1.data_a}, 32'd20);
        check("t6_b20", {24'd0, bus1.data_b}, 32'd10);
        drive1(1'b1, 8'd30, 1'b0);
        check("t6_v30", {31'd0, bus1.out_valid}, 32'd1);
        check("t6_a30", {24'd0, bus1.data_a}, 32'd30);
        check("t6_b30", {24'd0, bus1.data_b}, 32'd20);
        #2 rst_n1 = 1'b0;
        #1;
        check("t6_async_valid",  {31'd0, bus1.out_valid}, 32'd0);
        check("t6_async_a",      {24'd0, bus1.data_a},    32'd0);
        check("t6_async_primed", {31'd0, bus1.primed},    32'd0);
        check("t6_async_fill",   {24'd0, bus1.fill_count}, 32'd0);
        @(negedge clk);
        rst_n1 = 1'b1;
        @(negedge clk);
        drive1(1'b1, 8'd40, 1'b0);
        check("t6_refill_valid",  {31'd0, bus1.out_valid}, 32'd0);
        check("t6_refill_primed", {31'd0, bus1.primed},    32'd1);
        drive1(1'b1, 8'd50, 1'b0);
        check("t6_a50", {24'd0, bus1.data_a}, 32'd50);
        check("t6_b50", {24'd0, bus1.data_b}, 32'd40);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
